// File: rtl/mem_port_arbiter.sv
// Unified memory-port arbiter between IF and MEM with RISC-V byte-lane generation.
// Optional saturating performance counters are compiled in with `define MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_misalign,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_conflict,
  output logic [CNT_W-1:0]  perf_busy
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                mis_q, mis_d;
  logic                drop_q, drop_d;
  logic                if_valid_q, if_valid_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic                d_valid_q, d_valid_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                d_misalign_q, d_misalign_d;

  logic if_want, d_want, drop_now, load;

  function automatic logic lane_misalign(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    if (lane_misalign(size, a)) return 4'b0000;
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // A requester keeps its request up through its valid pulse, so a request that
  // is being acked or is already answered must not win the bus a second time.
  assign if_want  = if_req & ~if_valid_q & ~if_flush;
  assign d_want   = d_req & ~d_valid_q;
  assign drop_now = drop_q | if_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mis_q        <= 1'b0;
      drop_q       <= 1'b0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_valid_q    <= 1'b0;
      d_rdata_q    <= '0;
      d_misalign_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mis_q        <= mis_d;
      drop_q       <= drop_d;
      if_valid_q   <= if_valid_d;
      if_rdata_q   <= if_rdata_d;
      d_valid_q    <= d_valid_d;
      d_rdata_q    <= d_rdata_d;
      d_misalign_q <= d_misalign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_want)       state_d = BUSY_D;
        else if (if_want) state_d = BUSY_I;
      end
      BUSY_D: begin
        if (mem_ack) state_d = if_want ? BUSY_I : IDLE;
      end
      BUSY_I: begin
        // A flushed fetch never answered its requester, so its new target may go next.
        if (mem_ack) begin
          if (d_want)                  state_d = BUSY_D;
          else if (drop_now && if_want) state_d = BUSY_I;
          else                         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load         = (state_q == IDLE) | mem_ack;
    mem_req_d    = (state_d != IDLE);
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mis_d        = mis_q;
    if (load && state_d == BUSY_D) begin
      mem_we_d    = d_we;
      mem_be_d    = lane_be(d_size, d_addr[1:0]);
      mem_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
      mem_wdata_d = lane_wdata(d_size, d_wdata);
      mis_d       = lane_misalign(d_size, d_addr[1:0]);
    end else if (load && state_d == BUSY_I) begin
      mem_we_d    = 1'b0;
      mem_be_d    = 4'b1111;
      mem_addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
      mem_wdata_d = '0;
      mis_d       = 1'b0;
    end

    drop_d       = (state_q == BUSY_I) && !mem_ack && drop_now;
    if_valid_d   = (state_q == BUSY_I) && mem_ack && !drop_now;
    if_rdata_d   = if_valid_d ? mem_rdata : if_rdata_q;
    d_valid_d    = (state_q == BUSY_D) && mem_ack;
    d_rdata_d    = d_valid_d ? mem_rdata : d_rdata_q;
    d_misalign_d = d_valid_d && mis_q;
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign if_valid   = if_valid_q;
  assign if_rdata   = if_rdata_q;
  assign d_valid    = d_valid_q;
  assign d_rdata    = d_rdata_q;
  assign d_misalign = d_misalign_q;
  assign if_stall   = if_req & ~if_valid_q;
  assign d_stall    = d_req & ~d_valid_q;

`ifdef MEM_ARB_PERF_EN
  logic [CNT_W-1:0] perf_conflict_q, perf_conflict_d;
  logic [CNT_W-1:0] perf_busy_q, perf_busy_d;

  always_comb begin
    perf_conflict_d = perf_conflict_q;
    perf_busy_d     = perf_busy_q;
    if (if_req && d_req && !if_valid_q && perf_conflict_q != '1)
      perf_conflict_d = perf_conflict_q + 1'b1;
    if (mem_req_q && perf_busy_q != '1)
      perf_busy_d = perf_busy_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_q <= '0;
      perf_busy_q     <= '0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_busy_q     <= perf_busy_d;
    end
  end

  assign perf_conflict = perf_conflict_q;
  assign perf_busy     = perf_busy_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory slave with programmable ack latency,
// a transaction-level expectation model and literal checks of the key scenarios.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_addr;
  logic        if_valid, if_stall, d_valid, d_misalign, d_stall, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;
  logic        mem_ack = 1'b0;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_conflict, perf_busy;
`endif

  mem_port_arbiter #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_misalign(d_misalign), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef MEM_ARB_PERF_EN
    , .perf_conflict(perf_conflict), .perf_busy(perf_busy)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct { logic [31:0] addr; bit we; logic [3:0] be; logic [31:0] wdata; } txn_t;
  typedef struct { logic [31:0] rdata; bit chk; bit mis; } dresp_t;

  txn_t        exp_txn[$];
  logic [31:0] exp_if[$];
  dresp_t      exp_d[$];

  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] bus_mem [logic [29:0]];

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return {16'hC0DE, w[15:0]};
  endfunction

  function automatic logic [31:0] bus_rd(input logic [29:0] w);
    if (bus_mem.exists(w)) return bus_mem[w];
    return {16'hC0DE, w[15:0]};
  endfunction

  // Access of 2^size bytes at byte offset a: lanes a..a+n-1, each lane carries data byte (lane mod n).
  function automatic void model_lanes(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                                      output logic [3:0] be, output logic [31:0] wo, output bit mis);
    int n;
    int off;
    n   = 1 << sz;
    off = int'(a[1:0]);
    mis = (sz == 2'b11) || (off % n != 0);
    be  = 4'b0000;
    for (int k = 0; k < 4; k++) wo[8*k +: 8] = wd[8*(k % n) +: 8];
    if (!mis) for (int k = 0; k < n; k++) be = be | (4'b0001 << (off + k));
  endfunction

  task automatic push_fetch(input logic [31:0] a, input bit resp);
    txn_t t;
    t.addr = {a[31:2], 2'b00}; t.we = 1'b0; t.be = 4'b1111; t.wdata = '0;
    exp_txn.push_back(t);
    if (resp) exp_if.push_back(ref_rd(a[31:2]));
  endtask

  task automatic push_data(input bit we, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input bit resp);
    txn_t t;
    dresp_t r;
    logic [31:0] old;
    t.addr = {a[31:2], 2'b00}; t.we = we;
    model_lanes(sz, a, wd, t.be, t.wdata, r.mis);
    exp_txn.push_back(t);
    old = ref_rd(a[31:2]);
    r.rdata = old; r.chk = !we;
    if (resp) exp_d.push_back(r);
    if (we) begin
      for (int k = 0; k < 4; k++) if (t.be[k]) old[8*k +: 8] = t.wdata[8*k +: 8];
      ref_mem[a[31:2]] = old;
    end
  endtask

  // Memory slave plus per-cycle compare process.
  int          ack_lat = 1;
  int          bcnt = 0;
  int          st_cyc = 0;
  logic [31:0] st_addr, st_wdata;
  logic        st_we;
  logic [3:0]  st_be;
  txn_t        e;
  logic [31:0] ei;
  dresp_t      ed;
  logic [31:0] w;

  always @(negedge clk) begin
    if (!mem_req) begin
      bcnt = 0; mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    end else begin
      if (mem_ack) bcnt = 0;
      bcnt++;
      if (bcnt == 1) begin
        st_addr = mem_addr; st_we = mem_we; st_be = mem_be; st_wdata = mem_wdata; st_cyc = cyc;
        if (exp_txn.size() == 0) chk("unexpected_bus_txn", 1, 0);
        else begin
          e = exp_txn.pop_front();
          chk("txn_addr", mem_addr, e.addr);
          chk("txn_we", mem_we, e.we);
          chk("txn_be", mem_be, e.be);
          if (e.we) chk("txn_wdata", mem_wdata, e.wdata);
        end
      end else begin
        chk("txn_hold_addr", mem_addr, st_addr);
        chk("txn_hold_ctl", {mem_we, mem_be, mem_wdata}, {st_we, st_be, st_wdata});
      end
      mem_ack = (bcnt >= ack_lat);
      mem_rdata = 32'hDEAD_BEEF;
      if (mem_ack) begin
        w = bus_rd(mem_addr[31:2]);
        mem_rdata = w;
        if (mem_we) begin
          for (int k = 0; k < 4; k++) if (mem_be[k]) w[8*k +: 8] = mem_wdata[8*k +: 8];
          bus_mem[mem_addr[31:2]] = w;
        end
      end
    end
    chk("if_stall", if_stall, if_req & ~if_valid);
    chk("d_stall", d_stall, d_req & ~d_valid);
    chk("mem_addr_align", mem_addr[1:0], 2'b00);
    if (if_valid) begin
      if (exp_if.size() == 0) chk("unexpected_if_valid", 1, 0);
      else begin ei = exp_if.pop_front(); chk("if_rdata", if_rdata, ei); end
    end
    if (d_valid) begin
      if (exp_d.size() == 0) chk("unexpected_d_valid", 1, 0);
      else begin
        ed = exp_d.pop_front();
        if (ed.chk) chk("d_rdata", d_rdata, ed.rdata);
        chk("d_misalign", d_misalign, ed.mis);
      end
    end else chk("d_misalign_idle", d_misalign, 1'b0);
  end

  task automatic run(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                     input logic [1:0] ds, input logic [31:0] da, input logic [31:0] dwd,
                     output int t0, output int irel, output int drel, output bit dmis);
    bit idone, ddone;
    @(posedge clk); #1;
    t0 = cyc; irel = -1; drel = -1; dmis = 1'b0; idone = !ir; ddone = !dr;
    if (dr) push_data(dwe, ds, da, dwd, 1'b1);
    if (ir) push_fetch(ia, 1'b1);
    if_req = ir; if_addr = ia;
    d_req = dr; d_we = dwe; d_size = ds; d_addr = da; d_wdata = dwd;
    for (int k = 0; k < 40 && !(idone && ddone); k++) begin
      @(negedge clk);
      if (if_valid && !idone) begin idone = 1'b1; irel = cyc - t0; end
      if (d_valid && !ddone) begin ddone = 1'b1; drel = cyc - t0; dmis = d_misalign; end
      @(posedge clk); #1;
      if (idone) if_req = 1'b0;
      if (ddone) d_req = 1'b0;
    end
    if (!(idone && ddone)) begin
      chk("valid_timeout", 0, 1);
      if_req = 1'b0; d_req = 1'b0;
    end
  endtask

  task automatic wait_if(input int t0, output int rel);
    bit done;
    done = 1'b0; rel = -1;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      if (if_valid) begin done = 1'b1; rel = cyc - t0; end
    end
    if (!done) chk("if_valid_timeout", 0, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  int t0, irel, drel, rel;
  bit dmis;
  logic [31:0] prev_if;

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_ctl", {mem_req, mem_we, mem_be, mem_addr}, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_if", {if_valid, if_stall, if_rdata}, '0);
    chk("rst_d", {d_valid, d_misalign, d_stall, d_rdata}, '0);
    rst_n = 1'b1;

    // Plain fetch, ack one cycle after request
    ack_lat = 1;
    run(1, 32'h100, 0, 0, 2'b10, 0, 0, t0, irel, drel, dmis);
    chk("fetch_valid_cycle", irel, 2);
    chk("fetch_req_cycle", st_cyc - t0, 1);
    chk("fetch_addr", st_addr, 32'h100);
    chk("fetch_be_we", {st_be, st_we}, {4'b1111, 1'b0});
    chk("fetch_rdata", if_rdata, 32'hC0DE0040);

    // Fetch and lw rise together: data first, fetch right behind
    run(1, 32'h104, 1, 0, 2'b10, 32'h2000, 0, t0, irel, drel, dmis);
    chk("both_d_valid_cycle", drel, 2);
    chk("both_i_valid_cycle", irel, 3);
    chk("both_fetch_req_cycle", st_cyc - t0, 2);
    chk("both_d_rdata", d_rdata, 32'hC0DE0800);
    chk("both_if_rdata", if_rdata, 32'hC0DE0041);

    // sb to byte 3
    run(0, 0, 1, 1, 2'b00, 32'h2003, 32'h0000_00AB, t0, irel, drel, dmis);
    chk("sb_be", st_be, 4'b1000);
    chk("sb_wdata", st_wdata, 32'hABAB_ABAB);
    chk("sb_we_addr", {st_we, st_addr}, {1'b1, 32'h2000});
    chk("sb_mem", bus_rd(30'h800), 32'hABDE_0800);
    chk("sb_misalign", dmis, 1'b0);
    run(0, 0, 1, 0, 2'b00, 32'h2003, 0, t0, irel, drel, dmis);
    chk("lbu_be", st_be, 4'b1000);
    chk("lbu_raw_rdata", d_rdata, 32'hABDE_0800);

    // Misaligned sw runs with no lanes
    run(0, 0, 1, 1, 2'b10, 32'h2002, 32'hFFFF_FFFF, t0, irel, drel, dmis);
    chk("sw_mis_be", st_be, 4'b0000);
    chk("sw_mis_flag", dmis, 1'b1);
    chk("sw_mis_mem", bus_rd(30'h800), 32'hABDE_0800);

    // Halfwords with two-cycle ack
    ack_lat = 2;
    run(0, 0, 1, 1, 2'b01, 32'h2002, 32'h0000_1234, t0, irel, drel, dmis);
    chk("sh_be", st_be, 4'b1100);
    chk("sh_wdata", st_wdata, 32'h1234_1234);
    chk("sh_mem", bus_rd(30'h800), 32'h1234_0800);
    chk("sh_d_valid_cycle", drel, 3);
    run(0, 0, 1, 0, 2'b01, 32'h2001, 0, t0, irel, drel, dmis);
    chk("lh_mis_flag", dmis, 1'b1);
    chk("lh_mis_be", st_be, 4'b0000);
    run(0, 0, 1, 0, 2'b11, 32'h2000, 0, t0, irel, drel, dmis);
    chk("size3_mis_flag", dmis, 1'b1);
    run(1, 32'h108, 1, 0, 2'b01, 32'h2006, 0, t0, irel, drel, dmis);
    chk("lat2_d_valid_cycle", drel, 3);
    chk("lat2_i_valid_cycle", irel, 5);
    chk("lat2_lh_be", {mem_be, st_cyc - t0}, {4'b1111, 32'd3});
    chk("lat2_lh_rdata", d_rdata, 32'hC0DE_0801);

    // Flush during a fetch with three-cycle ack: old fetch dropped, new target follows
    ack_lat = 3;
    prev_if = if_rdata;
    @(posedge clk); #1;
    t0 = cyc; if_req = 1'b1; if_addr = 32'h200; push_fetch(32'h200, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    if_flush = 1'b1; if_addr = 32'h300; push_fetch(32'h300, 1'b1);
    @(posedge clk); #1;
    if_flush = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_no_valid", if_valid, 1'b0);
    chk("flush_rdata_kept", if_rdata, prev_if);
    wait_if(t0, rel);
    chk("flush_refetch_valid_cycle", rel, 7);
    chk("flush_refetch_req_cycle", st_cyc - t0, 4);
    chk("flush_refetch_rdata", if_rdata, 32'hC0DE_00C0);

    // Flush in IDLE blocks the grant for that cycle only
    ack_lat = 1;
    @(posedge clk); #1;
    t0 = cyc; if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h10C; push_fetch(32'h10C, 1'b1);
    @(posedge clk); #1;
    if_flush = 1'b0;
    wait_if(t0, rel);
    chk("idle_flush_valid_cycle", rel, 3);
    chk("idle_flush_req_cycle", st_cyc - t0, 2);

    // Asynchronous reset in the middle of a data transaction
    ack_lat = 5;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h2004;
    push_data(1'b0, 2'b10, 32'h2004, 0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_mem_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_ctl", {mem_req, mem_we, mem_be, mem_addr}, '0);
    chk("async_rst_resp", {if_valid, d_valid, d_misalign, if_rdata}, '0);
    chk("async_rst_d_rdata", d_rdata, '0);
    d_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ack_lat = 1;
    run(1, 32'h104, 0, 0, 2'b10, 0, 0, t0, irel, drel, dmis);
    chk("post_rst_fetch_cycle", irel, 2);
    chk("post_rst_fetch_rdata", if_rdata, 32'hC0DE_0041);

    repeat (3) @(posedge clk);
    chk("exp_txn_drained", exp_txn.size(), 0);
    chk("exp_if_drained", exp_if.size(), 0);
    chk("exp_d_drained", exp_d.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
